// File: rtl/cpu24_mem_pkg.sv
// Shared types and constants for the 24-bit CPU data-memory path (big-endian, byte-addressed).
package cpu24_mem_pkg;

    localparam int DATA_W         = 24;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 3;
    localparam int MEM_BYTES      = 128;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } lss_state_t;

    // Byte idx of a word in big-endian order: idx 0 is the most significant byte.
    function automatic logic [BYTE_W-1:0] be_byte(input logic [DATA_W-1:0] word,
                                                  input logic [1:0]        idx);
        logic [BYTE_W-1:0] b;
        case (idx)
            2'd0:    b = word[23:16];
            2'd1:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/load_store_sequencer.sv
// Sequences one load/store as big-endian byte accesses on an 8-bit memory port, with range check.
// Latency: N access cycles then one DONE cycle (error: DONE directly); Start ignored while Busy.
module load_store_sequencer #(
    parameter int MEM_BYTES = cpu24_mem_pkg::MEM_BYTES,
    parameter int ADDR_W    = 7
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              IsStore,
    input  logic              IsByte,
    input  logic [23:0]       Address,
    input  logic [23:0]       StoreData,
    output logic              Busy,
    output logic              Done,
    output logic [23:0]       LoadData,
    output logic              AddrError,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [7:0]        MemWriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [7:0]        MemReadData
);
    import cpu24_mem_pkg::*;

    lss_state_t          state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic                is_store_q, is_store_d;
    logic                is_byte_q, is_byte_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   load_q, load_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [DATA_W:0]     req_end;
    logic                in_range;
    logic [1:0]          last_idx;
    logic                access;

    // One spare bit so Address near 2**24 cannot wrap back into range.
    assign req_end  = {1'b0, Address} + (IsByte ? (DATA_W+1)'(1) : (DATA_W+1)'(BYTES_PER_WORD));
    assign in_range = (req_end <= (DATA_W+1)'(MEM_BYTES));
    assign last_idx = is_byte_q ? 2'd0 : 2'(BYTES_PER_WORD - 1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        is_store_d = is_store_q;
        is_byte_d  = is_byte_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        load_d     = load_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    is_store_d = IsStore;
                    is_byte_d  = IsByte;
                    addr_d     = Address[ADDR_W-1:0];
                    wdata_d    = StoreData;
                    load_d     = '0;
                    idx_d      = 2'd0;
                    if (in_range) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // Shifting in from the right leaves a byte load zero-extended.
                if (!is_store_q) begin
                    load_d = {load_q[DATA_W-BYTE_W-1:0], MemReadData};
                end
                if (idx_q == last_idx) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    idx_d   = 2'd0;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            is_store_q <= 1'b0;
            is_byte_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            load_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            is_store_q <= is_store_d;
            is_byte_q  <= is_byte_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            load_q     <= load_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Reset masks the strobes combinationally so an interrupted access writes nothing more.
    assign access = (state_q == ACCESS) && !Reset;

    assign Busy         = (state_q != IDLE);
    assign Done         = done_q;
    assign AddrError    = err_q;
    assign LoadData     = load_q;
    assign MemRead      = access && !is_store_q;
    assign MemWrite     = access && is_store_q;
    assign MemAddress   = access ? (addr_q + ADDR_W'(idx_q)) : '0;
    assign MemWriteData = (access && is_store_q)
                        ? (is_byte_q ? wdata_q[7:0] : be_byte(wdata_q, idx_q))
                        : '0;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed and randomized bench for load_store_sequencer against a big-endian byte memory model.
module tb_load_store_sequencer;

    localparam int MB = cpu24_mem_pkg::MEM_BYTES;
    localparam int AW = 7;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Start;
    logic          IsStore;
    logic          IsByte;
    logic [23:0]   Address;
    logic [23:0]   StoreData;
    logic          Busy;
    logic          Done;
    logic [23:0]   LoadData;
    logic          AddrError;
    logic [AW-1:0] MemAddress;
    logic [7:0]    MemWriteData;
    logic          MemWrite;
    logic          MemRead;
    logic [7:0]    MemReadData;

    logic [7:0]    mem     [MB];
    logic [7:0]    ref_mem [MB];

    int checks = 0;
    int errors = 0;

    load_store_sequencer #(.MEM_BYTES(MB), .ADDR_W(AW)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Start        (Start),
        .IsStore      (IsStore),
        .IsByte       (IsByte),
        .Address      (Address),
        .StoreData    (StoreData),
        .Busy         (Busy),
        .Done         (Done),
        .LoadData     (LoadData),
        .AddrError    (AddrError),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .MemReadData  (MemReadData)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (MemWrite) mem[MemAddress] <= MemWriteData;
    end
    assign MemReadData = mem[MemAddress];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_mem(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < MB; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic scramble();
        IsStore   = 1'($urandom);
        IsByte    = 1'($urandom);
        Address   = 24'($urandom);
        StoreData = 24'($urandom);
    endtask

    // Model: a request covers bytes a..a+n-1 if they all exist; word bytes go MSB first.
    task automatic do_req(input string tag, input bit st, input bit by, input logic [23:0] a,
                          input logic [23:0] d, input bit hammer, output logic [23:0] ld);
        int          n, s, lat;
        bit          inr, got_done;
        logic [23:0] exp_ld;
        n      = by ? 1 : 3;
        inr    = (int'(a) + n) <= MB;
        exp_ld = '0;
        if (inr) begin
            for (int k = 0; k < n; k++) begin
                if (st) ref_mem[int'(a) + k] = by ? d[7:0] : d[8*(2-k) +: 8];
                else    exp_ld = (exp_ld << 8) | 24'(ref_mem[int'(a) + k]);
            end
        end
        ld = 'x;
        @(negedge Clock);
        Start = 1'b1; IsStore = st; IsByte = by; Address = a; StoreData = d;
        s = 0; lat = 0; got_done = 0;
        for (int c = 1; c <= 8 && !got_done; c++) begin
            @(negedge Clock);
            if (MemWrite || MemRead) begin
                chk({tag, "_strobe_kind"}, {MemWrite, MemRead}, {st, !st});
                chk({tag, "_addr"}, MemAddress, 32'((int'(a) + s) % MB));
                if (st) chk({tag, "_wdata"}, MemWriteData, by ? d[7:0] : d[8*(2-s) +: 8]);
                s++;
            end
            if (Done) begin
                got_done = 1;
                lat      = c;
                ld       = LoadData;
                chk({tag, "_busy_in_done"}, Busy, 1);
                chk({tag, "_err"}, AddrError, !inr);
                chk({tag, "_load"}, LoadData, exp_ld);
            end
            Start = hammer;
            scramble();
        end
        chk({tag, "_done_seen"}, got_done, 1);
        chk({tag, "_latency"}, lat, inr ? n + 1 : 1);
        chk({tag, "_strobes"}, s, inr ? n : 0);
        @(negedge Clock);
        chk({tag, "_single_done"}, {Done, Busy, MemWrite, MemRead}, 0);
        chk({tag, "_load_held"}, LoadData, exp_ld);
        Start = 1'b0;
        chk_mem({tag, "_mem"});
    endtask

    initial begin
        logic [23:0] ld;
        bit          st, by, hm;
        logic [23:0] a;

        for (int i = 0; i < MB; i++) begin
            logic [7:0] v;
            v          = 8'($urandom);
            mem[i]     <= v;
            ref_mem[i] = v;
        end
        Reset = 1'b1; Start = 1'b0;
        scramble();
        repeat (3) @(negedge Clock);
        chk("reset_ctrl", {Busy, Done, AddrError, MemWrite, MemRead}, 0);
        chk("reset_bus", {MemAddress, MemWriteData}, 0);
        chk("reset_load", LoadData, 0);
        Reset = 1'b0;

        do_req("t1_word_store", 1, 0, 24'd4, 24'hABCDEF, 0, ld);
        chk("t1_bytes", {mem[4], mem[5], mem[6]}, 24'hABCDEF);
        do_req("t2_word_load", 0, 0, 24'd4, 24'h0, 0, ld);
        chk("t2_value", ld, 24'hABCDEF);
        do_req("t3_byte_store", 1, 1, 24'd127, 24'h123456, 0, ld);
        chk("t3_byte", mem[127], 8'h56);
        do_req("t3_byte_load", 0, 1, 24'd127, 24'h0, 0, ld);
        chk("t3_value", ld, 24'h000056);
        do_req("t4_oob_126", 0, 0, 24'd126, 24'h0, 0, ld);
        do_req("t4_oob_max", 0, 0, 24'hFFFFFF, 24'h0, 0, ld);
        do_req("t5_hammer", 1, 0, 24'd20, 24'h5A3C96, 1, ld);

        // Reset lands on the second access cycle of a word store.
        @(negedge Clock);
        Start = 1'b1; IsStore = 1'b1; IsByte = 1'b0; Address = 24'd10; StoreData = 24'h1F2E3D;
        ref_mem[10] = 8'h1F;
        @(negedge Clock);
        Start = 1'b0;
        chk("t6_first_write", {MemWrite, MemAddress}, {1'b1, 7'd10});
        @(negedge Clock);
        chk("t6_second_write", {MemWrite, MemAddress}, {1'b1, 7'd11});
        Reset = 1'b1;
        #1;
        chk("t6_strobe_drop", {MemWrite, MemRead}, 0);
        @(negedge Clock);
        Reset = 1'b0;
        chk("t6_reset_ctrl", {Busy, Done, AddrError, MemWrite, MemRead}, 0);
        chk("t6_reset_bus", {MemAddress, MemWriteData}, 0);
        chk("t6_reset_load", LoadData, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge Clock);
            chk("t6_no_done", {Done, Busy}, 0);
        end
        chk_mem("t6_mem");

        for (int r = 0; r < 40; r++) begin
            st = 1'($urandom);
            by = 1'($urandom);
            hm = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) a = 24'hFFFFFF - 24'($urandom_range(0, 3));
            else                           a = 24'($urandom_range(0, MB + 2));
            do_req("rand", st, by, a, 24'($urandom), hm, ld);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
